// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM burst-port arbiter: FSM encoding, width helper
// and the address/length defaults that match the SDRAM controller parameter header.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam int DEF_ASIZE = 23;
  localparam int DEF_LSIZE = 9;

  // Width of an index into n items; never narrower than one bit.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request at or after the pointer,
// wrapping modulo NPORT, wins.
module rr_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int IW    = clog2(NPORT)
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [NPORT-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    cand    = '0;
    valid_o = |req_i;
    for (int off = NPORT - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr_i) + off) % NPORT);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that owns the SDRAM controller command port, tracking each
// burst from grant through CMD_DONE (or timeout) and returning completion to its owner.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NPORT   = 4,
  parameter int ASIZE   = DEF_ASIZE,
  parameter int LSIZE   = DEF_LSIZE,
  parameter int TIMEOUT = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NPORT-1:0]       REQ,
  input  logic [NPORT-1:0]       REQ_WE,
  input  logic [NPORT*ASIZE-1:0] REQ_ADDR,
  input  logic [NPORT*LSIZE-1:0] REQ_LEN,
  output logic [NPORT-1:0]       GNT,
  output logic [NPORT-1:0]       DONE,
  output logic                   CMD_REQ,
  output logic                   CMD_WE,
  output logic [ASIZE-1:0]       CMD_ADDR,
  output logic [LSIZE-1:0]       CMD_LEN,
  input  logic                   CMD_ACK,
  input  logic                   CMD_DONE,
  output logic                   ERR,
  output logic [2:0]             ERR_PORT
);

  localparam int IW = clog2(NPORT);
  localparam int TW = clog2(TIMEOUT);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NPORT-1:0]   gnt_q, gnt_d;
  logic [NPORT-1:0]   done_q, done_d;
  logic               cmd_req_q, cmd_req_d;
  logic               cmd_we_q, cmd_we_d;
  logic [ASIZE-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LSIZE-1:0]   cmd_len_q, cmd_len_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [2:0]         err_port_q, err_port_d;

  logic [ASIZE-1:0]   addrA [NPORT];
  logic [LSIZE-1:0]   lenA  [NPORT];
  logic [NPORT-1:0]   reqMasked;
  logic [NPORT-1:0]   pickOh;
  logic [IW-1:0]      pickIdx;
  logic               pickVld;
  logic               winZero;
  logic               timeoutHit;

  function automatic logic [IW-1:0] nextPtr(input logic [IW-1:0] idx);
    if (int'(idx) == NPORT - 1) return '0;
    else return idx + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      addrA[i] = REQ_ADDR[i*ASIZE +: ASIZE];
      lenA[i]  = REQ_LEN[i*LSIZE +: LSIZE];
    end
  end

  // A port just handed DONE may still show REQ this cycle; keep it out of the scan.
  assign reqMasked  = REQ & ~done_q;
  assign winZero    = (lenA[pickIdx] == '0);
  assign timeoutHit = (cnt_q == TW'(TIMEOUT - 1));

  rr_pick #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_pick (
    .req_i   (reqMasked),
    .ptr_i   (ptr_q),
    .gnt_o   (pickOh),
    .idx_o   (pickIdx),
    .valid_o (pickVld)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pickVld && !winZero)    state_d = ST_ISSUE;
      ST_ISSUE: if (CMD_ACK)                state_d = ST_BUSY;
      ST_BUSY:  if (CMD_DONE || timeoutHit) state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    cmd_req_d  = cmd_req_q;
    cmd_we_d   = cmd_we_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_port_d = err_port_q;
    case (state_q)
      ST_IDLE: begin
        if (pickVld) begin
          if (winZero) begin
            done_d = pickOh;
            ptr_d  = nextPtr(pickIdx);
          end else begin
            gnt_d      = pickOh;
            owner_d    = pickIdx;
            cmd_req_d  = 1'b1;
            cmd_we_d   = REQ_WE[pickIdx];
            cmd_addr_d = addrA[pickIdx];
            cmd_len_d  = lenA[pickIdx];
          end
        end
      end
      ST_ISSUE: begin
        if (CMD_ACK) begin
          cmd_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_BUSY: begin
        if (CMD_DONE) begin
          done_d = gnt_q;
          gnt_d  = '0;
          ptr_d  = nextPtr(owner_q);
        end else if (timeoutHit) begin
          err_d      = 1'b1;
          err_port_d = 3'(owner_q);
          gnt_d      = '0;
          ptr_d      = nextPtr(owner_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      cmd_req_q  <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_port_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cmd_req_q  <= cmd_req_d;
      cmd_we_q   <= cmd_we_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_port_q <= err_port_d;
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign CMD_REQ  = cmd_req_q;
  assign CMD_WE   = cmd_we_q;
  assign CMD_ADDR = cmd_addr_q;
  assign CMD_LEN  = cmd_len_q;
  assign ERR      = err_q;
  assign ERR_PORT = err_port_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a table of single-port bursts plus
// hand-written sequences for round-robin, zero length, timeout and reset corners.
module tb_sdram_port_arbiter;

  localparam int NPORT   = 4;
  localparam int ASIZE   = 23;
  localparam int LSIZE   = 9;
  localparam int TIMEOUT = 32;

  logic                   clk;
  logic                   rst;
  logic [NPORT-1:0]       req;
  logic [NPORT-1:0]       reqWe;
  logic [NPORT*ASIZE-1:0] reqAddr;
  logic [NPORT*LSIZE-1:0] reqLen;
  logic [NPORT-1:0]       gnt;
  logic [NPORT-1:0]       done;
  logic                   cmdReq;
  logic                   cmdWe;
  logic [ASIZE-1:0]       cmdAddr;
  logic [LSIZE-1:0]       cmdLen;
  logic                   cmdAck;
  logic                   cmdDone;
  logic                   err;
  logic [2:0]             errPort;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    int               port;
    logic             we;
    logic [ASIZE-1:0] addr;
    logic [LSIZE-1:0] len;
    int               ackDelay;
    logic [NPORT-1:0] expGnt;
  } vec_t;

  vec_t vecs[4];

  sdram_port_arbiter #(
    .NPORT   (NPORT),
    .ASIZE   (ASIZE),
    .LSIZE   (LSIZE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .REQ      (req),
    .REQ_WE   (reqWe),
    .REQ_ADDR (reqAddr),
    .REQ_LEN  (reqLen),
    .GNT      (gnt),
    .DONE     (done),
    .CMD_REQ  (cmdReq),
    .CMD_WE   (cmdWe),
    .CMD_ADDR (cmdAddr),
    .CMD_LEN  (cmdLen),
    .CMD_ACK  (cmdAck),
    .CMD_DONE (cmdDone),
    .ERR      (err),
    .ERR_PORT (errPort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_cmd_req"}, 32'(cmdReq), 32'h0);
    checkOutput({tag, "_cmd_we"}, 32'(cmdWe), 32'h0);
    checkOutput({tag, "_cmd_addr"}, 32'(cmdAddr), 32'h0);
    checkOutput({tag, "_cmd_len"}, 32'(cmdLen), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'h0);
    checkOutput({tag, "_err_port"}, 32'(errPort), 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic setPort(input int p, input logic we, input logic [ASIZE-1:0] addr,
                         input logic [LSIZE-1:0] len);
    reqWe[p]                  = we;
    reqAddr[p*ASIZE +: ASIZE] = addr;
    reqLen[p*LSIZE +: LSIZE]  = len;
  endtask

  // One complete single-port burst with a stalled acknowledge.
  task automatic applyStimulus(input vec_t v);
    setPort(v.port, v.we, v.addr, v.len);
    req = '0;
    req[v.port] = 1'b1;
    step();
    checkOutput("vec_gnt", 32'(gnt), 32'(v.expGnt));
    checkOutput("vec_cmd_req", 32'(cmdReq), 32'h1);
    checkOutput("vec_cmd_we", 32'(cmdWe), 32'(v.we));
    checkOutput("vec_cmd_addr", 32'(cmdAddr), 32'(v.addr));
    checkOutput("vec_cmd_len", 32'(cmdLen), 32'(v.len));
    for (int i = 0; i < v.ackDelay; i++) begin
      step();
      checkOutput("vec_hold_cmd_req", 32'(cmdReq), 32'h1);
      checkOutput("vec_hold_cmd_addr", 32'(cmdAddr), 32'(v.addr));
    end
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    checkOutput("vec_ack_cmd_req", 32'(cmdReq), 32'h0);
    checkOutput("vec_busy_gnt", 32'(gnt), 32'(v.expGnt));
    step();
    cmdDone = 1'b1;
    step();
    cmdDone = 1'b0;
    req = '0;
    checkOutput("vec_done", 32'(done), 32'(v.expGnt));
    checkOutput("vec_done_gnt", 32'(gnt), 32'h0);
    step();
    checkOutput("vec_done_pulse_end", 32'(done), 32'h0);
  endtask

  initial begin
    logic [NPORT-1:0] expOh;
    int waited;
    rst     = 1'b1;
    req     = '0;
    reqWe   = '0;
    reqAddr = '0;
    reqLen  = '0;
    cmdAck  = 1'b0;
    cmdDone = 1'b0;

    vecs[0] = '{2, 1'b1, 23'h001000,  9'h100, 5, 4'b0100};
    vecs[1] = '{0, 1'b0, 23'h7FFFFF,  9'h001, 0, 4'b0001};
    vecs[2] = '{3, 1'b1, 23'h000000,  9'h1FF, 2, 4'b1000};
    vecs[3] = '{1, 1'b0, 23'h123456,  9'h008, 1, 4'b0010};

    step();
    checkResetState("reset");
    doReset();

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Continuous requests from all ports against a 10-cycle burst controller.
    doReset();
    for (int p = 0; p < NPORT; p++) setPort(p, p[0], 23'(32'h100 + p * 32'h10), 9'd4);
    req = '1;
    for (int k = 0; k < 6; k++) begin
      expOh = 4'b0001 << (k % NPORT);
      waited = 0;
      while (!cmdReq && waited < 30) begin
        step();
        waited++;
      end
      checkOutput("rr_cmd_req_seen", 32'(cmdReq), 32'h1);
      if (k > 0) checkOutput("rr_gap_cycles", 32'(waited), 32'd1);
      checkOutput("rr_gnt", 32'(gnt), 32'(expOh));
      checkOutput("rr_cmd_addr", 32'(cmdAddr), 32'h100 + (k % NPORT) * 32'h10);
      cmdAck = 1'b1;
      step();
      cmdAck = 1'b0;
      repeat (9) step();
      cmdDone = 1'b1;
      step();
      cmdDone = 1'b0;
      if (k == 5) req = '0;
      checkOutput("rr_done", 32'(done), 32'(expOh));
      checkOutput("rr_done_gnt", 32'(gnt), 32'h0);
    end
    step();
    checkOutput("rr_idle_cmd_req", 32'(cmdReq), 32'h0);

    // Zero-length request completes without a command, next pending port follows.
    doReset();
    setPort(1, 1'b0, 23'h000555, 9'd0);
    setPort(3, 1'b1, 23'h000777, 9'd4);
    req = 4'b1010;
    step();
    checkOutput("zero_done", 32'(done), 32'b0010);
    checkOutput("zero_cmd_req", 32'(cmdReq), 32'h0);
    checkOutput("zero_gnt", 32'(gnt), 32'h0);
    req = 4'b1000;
    step();
    checkOutput("zero_next_gnt", 32'(gnt), 32'b1000);
    checkOutput("zero_next_cmd_req", 32'(cmdReq), 32'h1);
    checkOutput("zero_next_addr", 32'(cmdAddr), 32'h777);
    checkOutput("zero_next_done_clear", 32'(done), 32'h0);
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    cmdDone = 1'b1;
    step();
    cmdDone = 1'b0;
    req = '0;
    checkOutput("zero_next_done", 32'(done), 32'b1000);

    // Request inputs change and REQ drops after the latch cycle.
    setPort(0, 1'b1, 23'h001111, 9'd16);
    req = 4'b0001;
    step();
    checkOutput("chg_cmd_addr_latched", 32'(cmdAddr), 32'h1111);
    setPort(0, 1'b0, 23'h002000, 9'd3);
    req = '0;
    step();
    checkOutput("chg_cmd_addr_held", 32'(cmdAddr), 32'h1111);
    checkOutput("chg_cmd_len_held", 32'(cmdLen), 32'd16);
    checkOutput("chg_cmd_we_held", 32'(cmdWe), 32'h1);
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    step();
    cmdDone = 1'b1;
    step();
    cmdDone = 1'b0;
    checkOutput("chg_done", 32'(done), 32'b0001);

    // Timeout on port 3: ERR rises exactly TIMEOUT cycles after the acknowledge.
    setPort(3, 1'b0, 23'h003333, 9'd16);
    req = 4'b1000;
    step();
    checkOutput("to_gnt", 32'(gnt), 32'b1000);
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    req = '0;
    repeat (TIMEOUT - 1) step();
    checkOutput("to_err_early", 32'(err), 32'h0);
    checkOutput("to_gnt_early", 32'(gnt), 32'b1000);
    step();
    checkOutput("to_err", 32'(err), 32'h1);
    checkOutput("to_err_port", 32'(errPort), 32'd3);
    checkOutput("to_gnt_clear", 32'(gnt), 32'h0);
    checkOutput("to_no_done", 32'(done), 32'h0);
    setPort(1, 1'b1, 23'h004444, 9'd2);
    req = 4'b0010;
    step();
    checkOutput("to_next_gnt", 32'(gnt), 32'b0010);
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    cmdDone = 1'b1;
    step();
    cmdDone = 1'b0;
    req = '0;
    checkOutput("to_next_done", 32'(done), 32'b0010);
    checkOutput("to_err_sticky", 32'(err), 32'h1);

    // Reset in BUSY clears outputs at once; pending requests restart from port 0.
    setPort(2, 1'b1, 23'h005555, 9'd8);
    req = 4'b0100;
    step();
    checkOutput("rst_pre_gnt", 32'(gnt), 32'b0100);
    cmdAck = 1'b1;
    step();
    cmdAck = 1'b0;
    req = 4'b0110;
    step();
    #2;
    rst = 1'b1;
    #1;
    checkResetState("rst_mid");
    step();
    rst = 1'b0;
    step();
    checkOutput("rst_rearb_gnt", 32'(gnt), 32'b0010);
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
